mmio_pwm_bank: RTL and testbench

MMIO_PWM_BANK -- requirements
Module: mmio_pwm_bank

---
 rtl/mmio_pwm_bank.sv | 143 ++++++++++++++
 tb/tb_mmio_pwm_bank.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_pwm_bank.sv
// Memory-mapped bank of PWM channels with double-buffered duty registers and
// a synchronized switch input register, on a single-word processor bus.
module mmio_pwm_bank #(
   parameter int unsigned CHANNELS  = 4,
   parameter int unsigned DUTY_W    = 10,
   parameter int unsigned SW_W      = 16,
   parameter int unsigned BASE_ADDR = 4096
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                wren,
   input  logic [31:0]         address,
   input  logic [31:0]         wdata,
   output logic [31:0]         rdata,
   output logic                hit,
   input  logic [SW_W-1:0]     sw,
   output logic [CHANNELS-1:0] pwm,
   output logic                wrap
);

   localparam int unsigned NUM_REGS = CHANNELS + 2;
   localparam int unsigned RUN_BIT  = 8;

   logic [SW_W-1:0]     sw_meta;
   logic [SW_W-1:0]     sw_sync;
   logic [CHANNELS-1:0] enable;
   logic                run;
   logic [DUTY_W-1:0]   cnt;
   logic [DUTY_W-1:0]   shadow [CHANNELS];
   logic [DUTY_W-1:0]   active [CHANNELS];

   logic [31:0]         offset_c;
   logic                in_range_c;
   logic                ctrl_wr_c;
   logic                run_next_c;
   logic                start_c;
   logic                roll_c;
   logic                load_c;
   logic [CHANNELS-1:0] duty_wr_c;
   logic [CHANNELS-1:0] pwm_next_c;
   logic [31:0]         rdata_next_c;
   logic                unused_wdata_c;

   // Address decode relative to the switch register; anything below BASE wraps high and misses.
   assign offset_c       = address - 32'(BASE_ADDR);
   assign in_range_c     = offset_c < 32'(NUM_REGS);
   assign ctrl_wr_c      = wren & (offset_c == 32'd1);
   assign run_next_c     = ctrl_wr_c ? wdata[RUN_BIT] : run;
   assign start_c        = run_next_c & ~run;
   assign roll_c         = run & (&cnt);
   assign load_c         = roll_c | start_c;
   assign unused_wdata_c = ^wdata;

   always_comb begin
      duty_wr_c  = '0;
      pwm_next_c = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         duty_wr_c[i]  = wren & (offset_c == 32'(i + 2));
         pwm_next_c[i] = run & enable[i] & (cnt < active[i]);
      end
   end

   // Read mux; duty reads expose the shadow, not the value currently driving the output.
   always_comb begin
      rdata_next_c = '0;
      if (offset_c == 32'd0) begin
         rdata_next_c = 32'(sw_sync);
      end else if (offset_c == 32'd1) begin
         rdata_next_c = 32'(enable) | (32'(run) << RUN_BIT);
      end
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (offset_c == 32'(i + 2)) begin
            rdata_next_c = 32'(shadow[i]);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= sw;
         sw_sync <= sw_meta;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rdata <= '0;
         hit   <= 1'b0;
      end else begin
         rdata <= rdata_next_c;
         hit   <= in_range_c;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         enable <= '0;
         run    <= 1'b0;
      end else if (ctrl_wr_c) begin
         enable <= wdata[CHANNELS-1:0];
         run    <= wdata[RUN_BIT];
      end
   end

   // Active duty only follows the shadow at period boundaries, so outputs never glitch.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (duty_wr_c[i]) begin
               shadow[i] <= wdata[DUTY_W-1:0];
            end
            if (load_c) begin
               active[i] <= shadow[i];
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt  <= '0;
         wrap <= 1'b0;
         pwm  <= '0;
      end else begin
         if (start_c) begin
            cnt <= '0;
         end else if (run) begin
            cnt <= cnt + DUTY_W'(1);
         end
         wrap <= roll_c & run_next_c;
         pwm  <= pwm_next_c;
      end
   end

endmodule

// File: tb/tb_mmio_pwm_bank.sv
// Bench for mmio_pwm_bank: directed scenarios with literal expectations plus a
// randomized bus phase, all checked every cycle against a behavioural model.
module tb_mmio_pwm_bank;

   localparam int unsigned CH   = 4;
   localparam int unsigned DW   = 4;
   localparam int unsigned SWW  = 16;
   localparam int unsigned BASE = 4096;
   localparam int          PER  = 16;

   logic           clock   = 1'b0;
   logic           reset_n = 1'b1;
   logic           wren    = 1'b0;
   logic [31:0]    address = '0;
   logic [31:0]    wdata   = '0;
   logic [31:0]    rdata;
   logic           hit;
   logic [SWW-1:0] sw      = '0;
   logic [CH-1:0]  pwm;
   logic           wrap;

   mmio_pwm_bank #(
      .CHANNELS (CH),
      .DUTY_W   (DW),
      .SW_W     (SWW),
      .BASE_ADDR(BASE)
   ) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .wren   (wren),
      .address(address),
      .wdata  (wdata),
      .rdata  (rdata),
      .hit    (hit),
      .sw     (sw),
      .pwm    (pwm),
      .wrap   (wrap)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   // Behavioural model state: what each register holds, in plain integers.
   int          m_cnt = 0;
   bit          m_run = 1'b0;
   bit [3:0]    m_en  = '0;
   int          m_shadow [4] = '{0, 0, 0, 0};
   int          m_active [4] = '{0, 0, 0, 0};
   int          m_sw1 = 0;
   int          m_sw2 = 0;
   logic [3:0]  e_pwm = '0;
   logic        e_wrap = 1'b0;
   logic        e_hit = 1'b0;
   logic [31:0] e_rdata = '0;

   int          cnt_hi [4];
   int          cnt_wrap;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_run = 1'b0; m_en = '0; m_sw1 = 0; m_sw2 = 0;
      for (int i = 0; i < 4; i++) begin
         m_shadow[i] = 0;
         m_active[i] = 0;
      end
      e_pwm = '0; e_wrap = 1'b0; e_hit = 1'b0; e_rdata = '0;
   endtask

   task automatic model_step();
      longint off;
      bit     roll;
      bit     start;
      bit     old_run;
      int     old_sh [4];
      off = longint'(address) - longint'(BASE);
      for (int i = 0; i < 4; i++) e_pwm[i] = m_run && m_en[i] && (m_cnt < m_active[i]);
      e_hit   = (off >= 0) && (off < longint'(2 + CH));
      e_rdata = '0;
      if (off == 0) e_rdata = 32'(m_sw2);
      else if (off == 1) e_rdata = 32'(m_en) + (m_run ? 32'd256 : 32'd0);
      else if (e_hit) e_rdata = 32'(m_shadow[int'(off) - 2]);
      roll    = m_run && (m_cnt == PER - 1);
      old_run = m_run;
      old_sh  = m_shadow;
      start   = 1'b0;
      if (wren && off == 1) begin
         start = wdata[8] && !m_run;
         m_run = wdata[8];
         m_en  = wdata[3:0];
      end else if (wren && e_hit && off >= 2) begin
         m_shadow[int'(off) - 2] = int'(wdata[3:0]);
      end
      e_wrap = roll && m_run;
      if (start) m_cnt = 0;
      else if (old_run) m_cnt = (m_cnt + 1) % PER;
      if (roll || start) m_active = old_sh;
      m_sw2 = m_sw1;
      m_sw1 = int'(sw);
   endtask

   initial forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
   end

   // Every-cycle comparison of all outputs against the model.
   initial forever begin
      @(negedge clock);
      if (chk_en) begin
         check("cyc_pwm", 32'(pwm), 32'(e_pwm));
         check("cyc_wrap", 32'(wrap), 32'(e_wrap));
         check("cyc_hit", 32'(hit), 32'(e_hit));
         check("cyc_rdata", rdata, e_rdata);
      end
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      wren = 1'b1; address = a; wdata = d;
      tick();
      wren = 1'b0; address = '0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic h);
      wren = 1'b0; address = a;
      @(posedge clock);
      @(negedge clock);
      d = rdata; h = hit;
      tick();
      address = '0;
   endtask

   // Observe n cycles, optionally issuing one store at cycle index wk.
   task automatic measure(input int n, input int wk, input logic [31:0] wa, input logic [31:0] wd);
      for (int i = 0; i < 4; i++) cnt_hi[i] = 0;
      cnt_wrap = 0;
      for (int k = 0; k < n; k++) begin
         if (k == wk) begin wren = 1'b1; address = wa; wdata = wd; end
         else begin wren = 1'b0; address = '0; end
         @(negedge clock);
         for (int i = 0; i < 4; i++) cnt_hi[i] += int'(pwm[i]);
         cnt_wrap += int'(wrap);
         tick();
      end
      wren = 1'b0; address = '0;
   endtask

   logic [31:0] rd_v;
   logic        rd_h;
   bit          seen;

   initial begin
      #3 reset_n = 1'b0;
      #1 chk_en = 1'b1;
      check("rst_pwm", 32'(pwm), 32'd0);
      check("rst_wrap", 32'(wrap), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_hit", 32'(hit), 32'd0);
      @(posedge clock); @(posedge clock); #2 reset_n = 1'b1;

      // Duty 5 on channel 0.
      wr(32'd4098, 32'd5);
      wr(32'd4097, 32'h101);
      measure(32, -1, '0, '0);
      check("run_hi0_32", 32'(cnt_hi[0]), 32'd10);
      check("run_wrap_32", 32'(cnt_wrap), 32'd1);
      measure(16, -1, '0, '0);
      check("run_hi0_16", 32'(cnt_hi[0]), 32'd5);
      check("run_wrap_16", 32'(cnt_wrap), 32'd1);

      // Edge duties 0 and 15.
      wr(32'd4097, 32'h0);
      wr(32'd4099, 32'd0);
      wr(32'd4100, 32'd15);
      wr(32'd4097, 32'h106);
      measure(1, -1, '0, '0);
      measure(16, -1, '0, '0);
      check("edge_hi1", 32'(cnt_hi[1]), 32'd0);
      check("edge_lo2", 32'(16 - cnt_hi[2]), 32'd1);
      check("edge_hi0", 32'(cnt_hi[0]), 32'd0);

      // Duty change mid-period applies only from the next period.
      wr(32'd4097, 32'h0);
      wr(32'd4098, 32'd5);
      wr(32'd4097, 32'h101);
      measure(17, 3, 32'd4098, 32'd9);
      check("glitch_cur", 32'(cnt_hi[0]), 32'd5);
      measure(16, -1, '0, '0);
      check("glitch_next", 32'(cnt_hi[0]), 32'd9);

      // Readback, miss, read-only switch register, read-during-write.
      sw = 16'hA5A5;
      tick(); tick(); tick();
      rd(32'd4096, rd_v, rd_h);
      check("rd_sw", rd_v, 32'h0000A5A5);
      check("rd_sw_hit", 32'(rd_h), 32'd1);
      rd(32'd5000, rd_v, rd_h);
      check("rd_miss", rd_v, 32'd0);
      check("rd_miss_hit", 32'(rd_h), 32'd0);
      wr(32'd4096, 32'h0);
      rd(32'd4096, rd_v, rd_h);
      check("rd_sw_ro", rd_v, 32'h0000A5A5);
      rd(32'd4097, rd_v, rd_h);
      check("rd_ctrl", rd_v, 32'h101);
      wren = 1'b1; address = 32'd4098; wdata = 32'd3;
      @(posedge clock);
      @(negedge clock);
      check("rd_pre_write", rdata, 32'd9);
      wren = 1'b0;
      tick();
      rd(32'd4098, rd_v, rd_h);
      check("rd_post_write", rd_v, 32'd3);

      // Enable drop while high.
      wr(32'd4098, 32'd12);
      seen = 1'b0;
      for (int k = 0; k < 64; k++) begin
         @(negedge clock);
         if (pwm[0]) begin seen = 1'b1; break; end
      end
      check("en_seen_high", 32'(seen), 32'd1);
      tick();
      wr(32'd4097, 32'h100);
      @(negedge clock);
      @(posedge clock);
      @(negedge clock);
      check("en_drop_pwm0", 32'(pwm[0]), 32'd0);
      tick();
      measure(16, -1, '0, '0);
      check("en_drop_hold", 32'(cnt_hi[0]), 32'd0);

      // Reset in the middle of a period.
      wr(32'd4097, 32'h10F);
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (m_cnt == 7) begin seen = 1'b1; break; end
         tick();
      end
      check("rst_found_cnt7", 32'(seen), 32'd1);
      reset_n = 1'b0;
      #1;
      check("rst7_pwm", 32'(pwm), 32'd0);
      check("rst7_wrap", 32'(wrap), 32'd0);
      check("rst7_rdata", rdata, 32'd0);
      check("rst7_hit", 32'(hit), 32'd0);
      @(posedge clock); @(posedge clock); #2 reset_n = 1'b1;
      measure(20, -1, '0, '0);
      check("rst7_quiet", 32'(cnt_hi[0] + cnt_hi[1] + cnt_hi[2] + cnt_hi[3]), 32'd0);
      check("rst7_nowrap", 32'(cnt_wrap), 32'd0);
      rd(32'd4097, rd_v, rd_h);
      check("rst7_ctrl", rd_v, 32'd0);
      wr(32'd4101, 32'd8);
      wr(32'd4097, 32'h108);
      measure(1, -1, '0, '0);
      measure(16, -1, '0, '0);
      check("rst7_restart_hi3", 32'(cnt_hi[3]), 32'd8);

      // Randomized bus traffic, checked only by the model.
      for (int k = 0; k < 2000; k++) begin
         if (!reset_n) reset_n = 1'b1;
         else if ($urandom_range(0, 499) == 0) reset_n = 1'b0;
         if ($urandom_range(0, 7) == 0) sw = SWW'($urandom);
         wren    = ($urandom_range(0, 3) == 0);
         address = BASE - 2 + $urandom_range(0, 9);
         if ($urandom_range(0, 15) == 0) address = $urandom;
         wdata = $urandom;
         if (address == BASE + 1) wdata[8] = ($urandom_range(0, 7) != 0);
         tick();
      end
      reset_n = 1'b1;
      wren = 1'b0;
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
